dm_wait_resp: RTL
=================

// Module: dm_wait_resp
// PURPOSE
//  Memory-side responder for the CPU data-memory interface, the target end of
//  load/store traffic. Adds a valid/ready request/response handshake and a
//  programmable wait-state count, so the datapath can be tested against
//  multi-cycle memory instead of the combinational 1 KB data RAM.
//  Owns a word-organised RAM with byte-enable writes. Flags misaligned accesses.
// PARAMETERS
//  ADDR_W       10  byte-address width; RAM holds 2**(ADDR_W-2) 32-bit words
//  WAIT_CYCLES   2  extra cycles between request accept and response (0..15)
// PORTS
//  clk         in   1       rising-edge clock; the only clock
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       responder can accept a request (1 only in IDLE)
//  req_we      in   1       1 = store, 0 = load
//  req_addr    in   ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]
//  req_wdata   in   32      store data
//  req_be      in   4       byte enables for stores; be[i] selects wdata[8i+7:8i]
//  resp_valid  out  1       response present
//  resp_ready  in   1       requester accepts the response
//  resp_rdata  out  32      load data (0 for stores and errors)
//  resp_err    out  1       1 = misaligned access (req_addr[1:0] != 0)
// BEHAVIOUR
//  States: IDLE, BUSY, RESP. All state, counter and outputs are registered.
//  Reset (rst=1 at an edge): state=IDLE, counter=0, resp_valid=0,
//   resp_rdata=0, resp_err=0, and the latched request is cleared.
//   After reset, req_ready=1. RAM contents are not cleared.
//  IDLE: req_ready=1. At an edge where req_valid=1, latch we/addr/wdata/be.
//   If WAIT_CYCLES=0, go to RESP; otherwise go to BUSY with counter=WAIT_CYCLES.
//  BUSY: req_ready=0. The counter decrements every edge.
//   At the edge where counter==1, commit the access and go to RESP.
//  Commit: the same edge that enters RESP.
//   - Aligned store: for each i with be[i]=1, RAM[word][8i+7:8i] <= wdata byte.
//     resp_rdata=0, resp_err=0.
//   - Aligned load: resp_rdata=RAM[word] (pre-commit value), resp_err=0.
//   - Misaligned (either type): no RAM change, resp_rdata=0, resp_err=1.
//   - Store with be=4'b0000: no RAM change, resp_err=0.
//  Latency: accept at edge E0. resp_valid=1 from edge E0+WAIT_CYCLES onward
//   (for WAIT_CYCLES=0, the cycle right after E0).
//  RESP: resp_valid=1 and req_ready=0.
//   resp_rdata and resp_err hold stable until the handshake.
//   At an edge with resp_ready=1: go to IDLE, resp_valid=0.
//   resp_rdata and resp_err keep their last value.
//   With resp_ready=0, stay in RESP indefinitely.
//  No new request is accepted in BUSY or RESP; req_valid is ignored there.
//   Peak throughput is one transaction per WAIT_CYCLES+2 cycles.
//  Reset mid-operation: rst during BUSY discards the request with no RAM write.
//   rst during RESP drops the response. The commit edge itself is suppressed
//   when rst=1 on that edge.
//  Request inputs are sampled only at the accept edge. Later changes have no effect.
// TESTING
//  1 Reset: hold rst 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  2 W=2: store addr 0x010 data 0xDEADBEEF be 4'hF, resp_ready=1
//    -> resp_valid high exactly 2 cycles after the accept edge, err=0.
//    Load 0x010 -> rdata=0xDEADBEEF.
//  3 Partial store: addr 0x010 data 0x11223344 be 4'b0101, then load
//    -> rdata=0xDE22BE44.
//  4 Misaligned load addr 0x013 -> resp_err=1, rdata=0.
//    Misaligned store addr 0x012 -> err=1, then load 0x010 is unchanged.
//  5 Backpressure: resp_ready=0 for 3 cycles in RESP -> valid/rdata stable,
//    req_ready=0. A req_valid pulse during that window is not accepted.
//  6 Reset in BUSY: store 0x020 data 0xCAFEF00D, assert rst one cycle after accept
//    -> no response; later load 0x020 returns the prior value.
//    Repeat with WAIT_CYCLES=0 -> back-to-back accepts every 2 cycles.

Source files
------------

// File: rtl/dm_wait_resp.sv
// dm_wait_resp: memory-side responder for the CPU data-memory interface.
// A request is accepted in IDLE and the access is committed after a
// programmable number of wait cycles. The response is then held in RESP
// until the requester takes it. The block owns a word-organised RAM with
// byte-enable writes, and it flags misaligned accesses.
module dm_wait_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o
);

  localparam int          WORDS     = 2 ** (ADDR_W - 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;

  // Latched request, captured only at the accept edge
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [31:0]         lat_wdata_q, lat_wdata_d;
  logic [3:0]          lat_be_q, lat_be_d;

  // Registered outputs
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic [31:0]         mem_q [WORDS];

  // Commit-side view of the request. With no wait cycles the access commits
  // on the accept edge itself, so it must come straight from the inputs.
  logic                commit;
  logic                com_we;
  logic [ADDR_W-1:0]   com_addr;
  logic [31:0]         com_wdata;
  logic [3:0]          com_be;
  logic                com_misaligned;
  logic [ADDR_W-3:0]   com_idx;
  logic                mem_wr_en;

  // Select where the committed access comes from: live inputs in IDLE, else the latch
  always_comb begin
    if (state_q == IDLE) begin
      com_we    = req_we_i;
      com_addr  = req_addr_i;
      com_wdata = req_wdata_i;
      com_be    = req_be_i;
    end else begin
      com_we    = lat_we_q;
      com_addr  = lat_addr_q;
      com_wdata = lat_wdata_q;
      com_be    = lat_be_q;
    end
    com_misaligned = (com_addr[1:0] != 2'b00);
    com_idx        = com_addr[ADDR_W-1:2];
  end

  // Next-state, counter, latch and registered-output logic for the handshake FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_be_d     = lat_be_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          lat_we_d    = req_we_i;
          lat_addr_d  = req_addr_i;
          lat_wdata_d = req_wdata_i;
          lat_be_d    = req_be_i;
          if (NO_WAIT) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // A count of zero cannot occur here; treat it like the final cycle
        // so that the FSM can never get stuck in BUSY.
        if (cnt_q <= 4'd1) begin
          commit  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (commit) begin
      resp_err_d   = com_misaligned;
      resp_rdata_d = (!com_we && !com_misaligned) ? mem_q[com_idx] : 32'h0;
    end

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  assign mem_wr_en = commit && com_we && !com_misaligned;

  // State, counter, latched request and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= 32'h0;
      lat_be_q     <= 4'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_be_q     <= lat_be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // RAM byte-lane writes on the commit edge; reset suppresses the write and never clears contents
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (com_be[i]) begin
          mem_q[com_idx][8*i +: 8] <= com_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
